// File: rtl/instr_prog_addr_gen.sv
// Instruction program address generator.
// Walks start_addr..end_addr (inclusive, wrapping through 2^ADDR_W-1) issuing
// one synchronous memory read per cycle. Returned words are held in a
// first-word-fall-through FIFO. A credit check on in-flight plus buffered
// words throttles issue so fetcher backpressure never drops a word.
// Optional feature macro: INSTR_PROG_ADDR_GEN_LOOP_EN adds loop_cnt and repeats
// the program loop_cnt+1 times without a bubble between iterations.
module instr_prog_addr_gen #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned INSTR_W    = 64,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = RD_LATENCY + 1,
    parameter int unsigned LOOP_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  end_addr,
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
    input  logic [LOOP_W-1:0]  loop_cnt,
`endif
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_out_vld,
    input  logic               fetcher_rdy
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    // Elaboration-time parameter legality checks
    generate
        if (RD_LATENCY < 1) begin : g_chk_lat
            $error("instr_prog_addr_gen: RD_LATENCY must be >= 1");
        end
        if (BUF_DEPTH < RD_LATENCY + 1) begin : g_chk_depth
            $error("instr_prog_addr_gen: BUF_DEPTH must be >= RD_LATENCY+1");
        end
        if (LOOP_W < 1) begin : g_chk_loop
            $error("instr_prog_addr_gen: LOOP_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   end_reg;
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
    logic [ADDR_W-1:0]   start_reg;
    logic [LOOP_W-1:0]   loop_left;
`endif
    logic [CNT_W-1:0]    inflight_cnt;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W-1:0]    fifo_cnt_nxt;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [INSTR_W-1:0]  fifo_mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                pop;
    logic                push;
    logic                issue;
    logic                last_addr;
    logic                drain_done;
    logic [SUM_W-1:0]    credit;

    // Wrap a FIFO pointer at BUF_DEPTH (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit-based issue decision, FIFO handshakes and drain completion
    always_comb begin
        pop          = instr_out_vld & fetcher_rdy;
        push         = vld_sr[RD_LATENCY-1];
        credit       = SUM_W'(inflight_cnt) + SUM_W'(fifo_cnt) - SUM_W'(pop);
        issue        = (state == RUN) && (credit < SUM_W'(BUF_DEPTH));
        last_addr    = (addr_reg == end_reg);
        fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        drain_done   = (state == DRAIN) && (inflight_cnt == '0) &&
                       (((fifo_cnt == CNT_W'(1)) && pop) || (fifo_cnt == '0));
        mem_rd_en    = issue;
        mem_rd_addr  = issue ? addr_reg : '0;
    end

    assign instr_out = fifo_mem[rd_ptr];

    // Program sequencing FSM with registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_reg <= '0;
            end_reg  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
            start_reg <= '0;
            loop_left <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped
                    if (start && !done) begin
                        addr_reg <= start_addr;
                        end_reg  <= end_addr;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
                        start_reg <= start_addr;
                        loop_left <= loop_cnt;
`endif
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                        if (last_addr) begin
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
                            // Reload for the next pass in the same cycle: no bubble
                            if (loop_left != '0) begin
                                addr_reg  <= start_reg;
                                loop_left <= loop_left - LOOP_W'(1);
                            end else begin
                                state <= DRAIN;
                            end
`else
                            state <= DRAIN;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-valid pipeline, in-flight tracking and output FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr        <= '0;
            inflight_cnt  <= '0;
            fifo_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            instr_out_vld <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            inflight_cnt  <= inflight_cnt + CNT_W'(issue) - CNT_W'(push);
            fifo_cnt      <= fifo_cnt_nxt;
            instr_out_vld <= (fifo_cnt_nxt != '0);
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rd_data;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // The credit rule must keep every push away from a full FIFO
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_instr_prog_addr_gen.sv
// Self-checking bench for instr_prog_addr_gen: expected addresses and words
// are queued when a program is launched and popped as the DUT issues reads
// and delivers instructions.
module tb_instr_prog_addr_gen;

    localparam int unsigned AW    = 16;
    localparam int unsigned IW    = 64;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [IW-1:0] mem_rd_data;
    logic [IW-1:0] instr_out;
    logic          instr_out_vld;
    logic          fetcher_rdy;
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
    logic [7:0]    loop_cnt;
`endif

    always #5 clk = ~clk;

    instr_prog_addr_gen #(
        .ADDR_W(AW), .INSTR_W(IW), .RD_LATENCY(LAT), .BUF_DEPTH(DEPTH), .LOOP_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .start_addr(start_addr), .end_addr(end_addr),
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
        .loop_cnt(loop_cnt),
`endif
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .instr_out(instr_out), .instr_out_vld(instr_out_vld), .fetcher_rdy(fetcher_rdy)
    );

    function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
        return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
    endfunction

    // Synchronous memory with LAT-cycle read latency; garbage when not valid
    logic [AW-1:0] mp_addr [LAT];
    logic          mp_en   [LAT];
    always @(posedge clk) begin
        mp_addr[0] <= mem_rd_addr;
        mp_en[0]   <= mem_rd_en;
        for (int i = 1; i < int'(LAT); i++) begin
            mp_addr[i] <= mp_addr[i-1];
            mp_en[i]   <= mp_en[i-1];
        end
    end
    assign mem_rd_data = (mp_en[LAT-1] === 1'b1) ? word_of(mp_addr[LAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;

    logic [AW-1:0] exp_addr [$];
    logic [IW-1:0] exp_data [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt, pop_cnt, done_cnt;
    int first_issue, last_issue, first_vld, first_pop, last_pop, done_cyc;

    // Scoreboard monitor, sampling on the falling edge
    task automatic monitor();
        logic [AW-1:0] ea;
        logic [IW-1:0] ed;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_rd_en === 1'b1) begin
                rd_cnt++;
                if (first_issue < 0) first_issue = cyc;
                last_issue = cyc;
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_addr: unexpected read of %h, none expected", mem_rd_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (mem_rd_addr !== ea) begin
                        n_fail++;
                        $display("FAIL rd_addr: got %h expected %h", mem_rd_addr, ea);
                    end
                end
            end
            if (instr_out_vld === 1'b1 && first_vld < 0) first_vld = cyc;
            if (instr_out_vld === 1'b1 && fetcher_rdy === 1'b1) begin
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n_checks++;
                if (exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL instr_out: unexpected word %h, none expected", instr_out);
                end else begin
                    ed = exp_data.pop_front();
                    if (instr_out !== ed) begin
                        n_fail++;
                        $display("FAIL instr_out: got %h expected %h", instr_out, ed);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic clear_track();
        rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
        first_issue = -1; last_issue = -1; first_vld = -1;
        first_pop = -1; last_pop = -1; done_cyc = -1;
    endtask

    // Queue expectations for a program, then pulse start for one cycle
    task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int loops);
        logic [AW-1:0] a;
        for (int l = 0; l <= loops; l++) begin
            a = sa;
            while (1'b1) begin
                exp_addr.push_back(a);
                exp_data.push_back(word_of(a));
                if (a == ea) break;
                a = a + 1'b1;
            end
        end
        clear_track();
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; end_addr = ea;
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
        loop_cnt = 8'(loops);
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, mem_rd_en, instr_out_vld} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_rd_en, instr_out_vld});
        end
        n_checks++;
        if (mem_rd_addr !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_rd_addr);
        end
        n_checks++;
        if (instr_out !== '0) begin
            n_fail++; $display("FAIL reset_instr: got %h expected 0", instr_out);
        end
        @(posedge clk); #1 rst = 1'b0;
        settle(2);
    endtask

    task automatic test_basic();
        bit ok;
        fetcher_rdy = 1'b1;
        launch(16'h0010, 16'h0013, 0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no done expected done"); end
        settle(5);
        n_checks++;
        if (rd_cnt != 4) begin n_fail++; $display("FAIL basic_reads: got %0d expected 4", rd_cnt); end
        n_checks++;
        if (last_issue - first_issue != 3) begin
            n_fail++; $display("FAIL basic_issue_span: got %0d expected 3", last_issue - first_issue);
        end
        n_checks++;
        if (first_vld - first_issue != int'(LAT) + 1) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected %0d", first_vld - first_issue, LAT + 1);
        end
        n_checks++;
        if (pop_cnt != 4 || last_pop - first_pop != 3) begin
            n_fail++; $display("FAIL basic_pops: got %0d over %0d expected 4 over 3", pop_cnt, last_pop - first_pop);
        end
        n_checks++;
        if (done_cyc - last_pop != 1) begin
            n_fail++; $display("FAIL basic_done_lat: got %0d expected 1", done_cyc - last_pop);
        end
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_once: got %0d busy=%b expected 1 busy=0", done_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        fetcher_rdy = 1'b0;
        launch(16'h0000, 16'h0009, 0);
        settle(15);
        n_checks++;
        if (rd_cnt != int'(DEPTH) || mem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_credit: got %0d reads en=%b expected %0d en=0", rd_cnt, mem_rd_en, DEPTH);
        end
        n_checks++;
        if (instr_out_vld !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got vld=%b busy=%b expected 1 1", instr_out_vld, busy);
        end
        fetcher_rdy = 1'b1;
        #1;
        n_checks++;
        if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b expected 1", mem_rd_en); end
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: got no done expected done"); end
        settle(3);
        n_checks++;
        if (rd_cnt != 10 || pop_cnt != 10 || exp_data.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d reads %0d pops expected 10 10", rd_cnt, pop_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        fetcher_rdy = 1'b1;
        launch(16'hFFFE, 16'h0001, 0);
        wait_done(100, ok);
        settle(4);
        n_checks++;
        if (!ok || rd_cnt != 4 || pop_cnt != 4 || done_cnt != 1) begin
            n_fail++; $display("FAIL wrap: got reads=%0d pops=%0d done=%0d expected 4 4 1", rd_cnt, pop_cnt, done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        fetcher_rdy = 1'b1;
        launch(16'h0030, 16'h0035, 0);
        settle(1);
        start = 1'b1; start_addr = 16'h0080; end_addr = 16'h0081;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, ok);
        settle(6);
        n_checks++;
        if (!ok || rd_cnt != 6 || pop_cnt != 6 || done_cnt != 1) begin
            n_fail++; $display("FAIL restart: got reads=%0d pops=%0d done=%0d expected 6 6 1", rd_cnt, pop_cnt, done_cnt);
        end
    endtask

    task automatic test_single_done_start();
        bit seen = 1'b0;
        fetcher_rdy = 1'b1;
        launch(16'h0005, 16'h0005, 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                start = 1'b1; start_addr = 16'h0070; end_addr = 16'h0071;
                @(posedge clk); #1 start = 1'b0;
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL single_done_timeout: got no done expected done"); end
        settle(8);
        n_checks++;
        if (rd_cnt != 1 || pop_cnt != 1 || done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single: got reads=%0d pops=%0d done=%0d busy=%b expected 1 1 1 0", rd_cnt, pop_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int rd_snap, pop_snap;
        fetcher_rdy = 1'b1;
        launch(16'h0040, 16'h004F, 0);
        for (int i = 0; i < 20; i++) begin
            if (rd_cnt >= 2) break;
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, mem_rd_en, instr_out_vld} !== 4'b0 || mem_rd_addr !== '0 || instr_out !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b addr=%h expected 0000 addr=0", {busy, done, mem_rd_en, instr_out_vld}, mem_rd_addr);
        end
        exp_addr.delete();
        exp_data.delete();
        rd_snap = rd_cnt;
        pop_snap = pop_cnt;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        settle(8);
        n_checks++;
        if (done_cnt != 0 || rd_cnt != rd_snap || pop_cnt != pop_snap) begin
            n_fail++; $display("FAIL abort_quiet: got done=%0d extra reads=%0d expected 0 0", done_cnt, rd_cnt - rd_snap);
        end
        launch(16'h0060, 16'h0062, 0);
        wait_done(100, ok);
        settle(4);
        n_checks++;
        if (!ok || pop_cnt != 3 || done_cnt != 1 || exp_data.size() != 0) begin
            n_fail++; $display("FAIL abort_rerun: got pops=%0d done=%0d expected 3 1", pop_cnt, done_cnt);
        end
    endtask

    task automatic test_random_stall();
        bit ok;
        logic [AW-1:0] sa;
        int len;
        for (int r = 0; r < 3; r++) begin
            sa  = AW'($urandom);
            len = int'($urandom_range(1, 12));
            fetcher_rdy = 1'($urandom_range(0, 1));
            launch(sa, sa + AW'(len - 1), 0);
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(posedge clk); #1;
                if (done_cnt > 0) begin ok = 1'b1; break; end
                fetcher_rdy = 1'($urandom_range(0, 1));
            end
            fetcher_rdy = 1'b1;
            settle(3);
            n_checks++;
            if (!ok || pop_cnt != len || done_cnt != 1 || exp_data.size() != 0) begin
                n_fail++; $display("FAIL rand_stall: got pops=%0d done=%0d expected %0d 1", pop_cnt, done_cnt, len);
            end
        end
    endtask

`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
    task automatic test_loop();
        bit ok;
        fetcher_rdy = 1'b1;
        launch(16'h0020, 16'h0021, 2);
        wait_done(100, ok);
        settle(5);
        n_checks++;
        if (!ok || rd_cnt != 6 || last_issue - first_issue != 5 || pop_cnt != 6 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL loop: got reads=%0d span=%0d done=%0d expected 6 5 1", rd_cnt, last_issue - first_issue, done_cnt);
        end
        loop_cnt = 8'd0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        start = 1'b0;
        start_addr = '0;
        end_addr = '0;
        fetcher_rdy = 1'b0;
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
        loop_cnt = 8'd0;
`endif
        clear_track();
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_restart_ignored();
        test_single_done_start();
        test_reset_abort();
        test_random_stall();
`ifdef INSTR_PROG_ADDR_GEN_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prog_addr_gen.md
Name: instr_prog_addr_gen

Overview:
Parametrised successor to the single-stream instruction address generator. It walks one instruction program from start_addr to end_addr (inclusive) on a start pulse and issues one read per cycle to the synchronous instruction memory. Returned read data is buffered in a credit-protected output FIFO, so fetcher backpressure never drops a word. It sits between the instruction memory and instr_fetcher.

Parameters:
ADDR_W, 16, instruction address width.
INSTR_W, 64, instruction word width.
RD_LATENCY, 1, memory read latency in cycles; must be >= 1.
BUF_DEPTH, RD_LATENCY+1, output FIFO entries; must be >= RD_LATENCY+1.
LOOP_W, 8, loop counter width; used only with the optional feature.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; launches a program when idle.
start_addr  in  ADDR_W  first address; sampled on an accepted start.
end_addr  in  ADDR_W  last address (inclusive); sampled on an accepted start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when the last word leaves the FIFO.
mem_rd_en  out  1  read strobe to the instruction memory.
mem_rd_addr  out  ADDR_W  read address; valid when mem_rd_en=1.
mem_rd_data  in  INSTR_W  read data; valid exactly RD_LATENCY cycles after mem_rd_en.
instr_out  out  INSTR_W  FIFO head word.
instr_out_vld  out  1  FIFO not empty.
fetcher_rdy  in  1  fetcher accepts instr_out this cycle.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; addr_reg, inflight_cnt, fifo_cnt and the valid shift register all 0; outputs busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, instr_out_vld=0, instr_out=0.
- Reset mid-program aborts the program; in-flight reads are discarded and no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches addr_reg=start_addr and end_reg=end_addr, then moves to RUN.
  - start is ignored in RUN and DRAIN.
- Issue rule, evaluated in RUN only: issue = (inflight_cnt + fifo_cnt - pop) < BUF_DEPTH, where pop = instr_out_vld & fetcher_rdy.
  - On an issue: mem_rd_en=1, mem_rd_addr=addr_reg, addr_reg <= addr_reg+1 (mod 2^ADDR_W).
  - mem_rd_en and mem_rd_addr are combinational from registered state plus pop.
- Last address: an issue with addr_reg==end_reg moves RUN to DRAIN.
  - If end_addr < start_addr, the address wraps through 2^ADDR_W-1 to 0. This is legal.
  - start_addr==end_addr issues exactly one read.
- Valid tracking: an RD_LATENCY-deep shift register carries mem_rd_en. Its tail writes mem_rd_data into the FIFO in the cycle the data is valid.
  - inflight_cnt increments on issue and decrements on that write; both in one cycle leaves it unchanged.
- FIFO is first-word-fall-through from registers.
  - instr_out_vld rises the cycle after the write, so latency is mem_rd_en to instr_out_vld = RD_LATENCY+1 cycles.
  - Simultaneous push and pop is allowed at any occupancy, including full.
  - The credit rule guarantees a push never meets a full FIFO. Assertion: push & full never occurs.
- Throughput: 1 instruction per cycle with fetcher_rdy held high. Stalls propagate to mem_rd_en within 0 cycles through the credit rule.
- DRAIN: when inflight_cnt==0, fifo_cnt==1 and pop=1 (or fifo_cnt==0 and inflight_cnt==0), assert done for 1 cycle, clear busy and return to IDLE.
  - A start in that same done cycle is ignored.
- Initial assertions: RD_LATENCY>=1; BUF_DEPTH>=RD_LATENCY+1.

Optional Feature:
Macro: INSTR_PROG_ADDR_GEN_LOOP_EN.
- Defined:
  - Adds input loop_cnt [LOOP_W-1:0], sampled on start.
  - The program runs loop_cnt+1 times. An issue at end_reg with iterations remaining reloads addr_reg=start_reg and stays in RUN, so no bubble is inserted between iterations.
  - DRAIN is entered only after the final iteration.
  - done pulses once, after the last word of the last iteration.
- Undefined: no loop_cnt port; exactly one pass.

Test Plan:
1. RD_LATENCY=1, start_addr=0x10, end_addr=0x13, fetcher_rdy=1 -> mem_rd_en high 4 consecutive cycles with addresses 0x10..0x13; instr_out_vld 2 cycles after the first issue; 4 words in order; done exactly 1 cycle after the last pop.
2. RD_LATENCY=3, BUF_DEPTH=4, fetcher_rdy=0 after start, range 0..9 -> exactly 4 reads issued, then mem_rd_en=0. Raise fetcher_rdy -> all 10 words delivered in order, no loss, no duplicates.
3. start_addr=0xFFFE, end_addr=0x0001 (ADDR_W=16) -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, then done.
4. start pulsed again while busy -> ignored, address sequence unchanged; start_addr==end_addr=0x5 -> single read, single word, done.
5. Assert rst asynchronously mid-RUN with 2 reads in flight -> all outputs 0 immediately; no done; a new start after release runs cleanly from the new start_addr.
6. With INSTR_PROG_ADDR_GEN_LOOP_EN, loop_cnt=2, range 0x20..0x21 -> addresses 20,21,20,21,20,21 back-to-back; done once.
